// File: rtl/ahb_pkg.sv
// Shared AHB types for the slave memory: transfer/size encodings, response codes,
// slave FSM states and the little-endian byte-enable decode.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Low address bits beyond the access size are ignored; unknown sizes act as word.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << addr;
            HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// DEPTH x 32 storage: cleared by async reset, byte-enable write port, async read port.
module ahb_mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB slave memory responder with programmable wait states.
// Define AHB_SLAVE_MEM_ERR_EN to build the two-cycle ERROR response for bad accesses.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    slv_state_e    state, state_nxt, tgt;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic          accept, take, wr_en;
    logic [31:0]   rdata;
    logic          unused_ok;

    assign accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    // A new address phase can only be taken where HREADYOUT is high.
    assign take   = accept && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);

`ifdef AHB_SLAVE_MEM_ERR_EN
    logic err;
    assign err = (HADDR[31:AW+2] != '0) || (HSIZE > 3'd2) ||
                 (HSIZE == HSIZE_HALF && HADDR[0]) ||
                 (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
    assign tgt = err ? ST_ERR1 : ((WAIT_CYCLES > 0) ? ST_WAIT : ST_DATA);
`else
    assign tgt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_DATA;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = take ? tgt : ST_IDLE;
            ST_WAIT: if (cnt <= CW'(1)) state_nxt = ST_DATA;
            ST_DATA: state_nxt = take ? tgt : ST_IDLE;
`ifdef AHB_SLAVE_MEM_ERR_EN
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: state_nxt = take ? tgt : ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                write_q <= HWRITE;
                cnt     <= CW'(WAIT_CYCLES);
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (take) begin
            addr_q <= HADDR;
            size_q <= HSIZE;
        end
    end

    assign wr_en = (state == ST_DATA) && write_q;

    ahb_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .we    (wr_en),
        .be    (byte_en(size_q, addr_q[1:0])),
        .waddr (addr_q[AW+1:2]),
        .wdata (HWDATA),
        .raddr (addr_q[AW+1:2]),
        .rdata (rdata)
    );

    assign HREADYOUT = !(state == ST_WAIT || state == ST_ERR1);
`ifdef AHB_SLAVE_MEM_ERR_EN
    assign HRESP = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign HRESP = HRESP_OKAY;
`endif
    assign HRDATA = (state == ST_DATA && !write_q) ? rdata : 32'h0;

    assign unused_ok = ^{HBURST, addr_q};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one zero-wait and one three-wait instance on a shared bus.
`timescale 1ns/1ps
module tb_ahb_slave_mem;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2, hburst = 3'd0;
    logic        hsel0 = 1'b0, hsel3 = 1'b0;
    logic        rdy0, rdy3;
    logic [1:0]  resp0, resp3;
    logic [31:0] rd0, rd3;
    int tests = 0;
    int fails = 0;

    always #5 HCLK = ~HCLK;

    ahb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy0),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

    ahb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy3),
        .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rd3));

    // Single non-pipelined transfer; returns final-cycle data/resp, low-ready cycle count
    // and the OR of HRESP seen during low-ready cycles.
    task automatic xfer(input int sel, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic [1:0] resp,
                        output int waits, output logic [1:0] wresp);
        int n;
        @(negedge HCLK);
        hsel0 = (sel == 0); hsel3 = (sel == 3);
        haddr = addr; htrans = 2'b10; hwrite = wr; hsize = size;
        @(negedge HCLK);
        hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwdata = wdata;
        waits = 0; wresp = 2'b00; n = 0;
        while (((sel == 0) ? rdy0 : rdy3) == 1'b0 && n < 40) begin
            waits++;
            wresp |= (sel == 0) ? resp0 : resp3;
            @(negedge HCLK);
            n++;
        end
        if (n >= 40) begin
            tests++; fails++;
            $display("FAIL xfer_timeout: ready still %b after %0d cycles, expected 1", 1'b0, n);
        end
        rdata = (sel == 0) ? rd0 : rd3;
        resp  = (sel == 0) ? resp0 : resp3;
    endtask

    task automatic test_reset();
        #2 HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        tests++; if (rdy0 !== 1'b1)   begin fails++; $display("FAIL reset_rdy0: got %b expected 1", rdy0); end
        tests++; if (resp0 !== 2'b00) begin fails++; $display("FAIL reset_resp0: got %b expected 00", resp0); end
        tests++; if (rd0 !== 32'h0)   begin fails++; $display("FAIL reset_rd0: got %h expected 0", rd0); end
        tests++; if (rdy3 !== 1'b1)   begin fails++; $display("FAIL reset_rdy3: got %b expected 1", rdy3); end
        tests++; if (resp3 !== 2'b00) begin fails++; $display("FAIL reset_resp3: got %b expected 00", resp3); end
        HRESETn = 1'b1;
        @(negedge HCLK);
        tests++; if (rd3 !== 32'h0)   begin fails++; $display("FAIL reset_rd3: got %h expected 0", rd3); end
    endtask

    task automatic test_back_to_back();
        int lows = 0;
        @(negedge HCLK);
        hsel0 = 1'b1; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(negedge HCLK);
        if (!rdy0) lows++;
        tests++; if (rd0 !== 32'h0) begin fails++; $display("FAIL b2b_wr_rdata: got %h expected 0", rd0); end
        hwdata = 32'hDEAD_BEEF; haddr = 32'h10; hwrite = 1'b0; htrans = 2'b10;
        @(negedge HCLK);
        if (!rdy0) lows++;
        tests++; if (rd0 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL b2b_rdata: got %h expected deadbeef", rd0); end
        tests++; if (resp0 !== 2'b00) begin fails++; $display("FAIL b2b_resp: got %b expected 00", resp0); end
        hsel0 = 1'b0; htrans = 2'b00;
        @(negedge HCLK);
        if (!rdy0) lows++;
        tests++; if (lows !== 0) begin fails++; $display("FAIL b2b_ready_low: got %0d low cycles expected 0", lows); end
        tests++; if (rd0 !== 32'h0) begin fails++; $display("FAIL b2b_idle_rdata: got %h expected 0", rd0); end
    endtask

    task automatic test_wait_states();
        logic [31:0] d; logic [1:0] r, wr; int w;
        xfer(3, 1'b0, 32'h04, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (w !== 3) begin fails++; $display("FAIL wait_count: got %0d expected 3", w); end
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL wait_rdata: got %h expected 0", d); end
        tests++; if ({wr, r} !== 4'b0000) begin fails++; $display("FAIL wait_resp: got %b expected 0000", {wr, r}); end
        xfer(3, 1'b1, 32'h0C, 3'd2, 32'h0BAD_F00D, d, r, w, wr);
        tests++; if (w !== 3) begin fails++; $display("FAIL wait_wr_count: got %0d expected 3", w); end
        xfer(3, 1'b0, 32'h0C, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (d !== 32'h0BAD_F00D) begin fails++; $display("FAIL wait_readback: got %h expected 0badf00d", d); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d; logic [1:0] r, wr; int w;
        xfer(0, 1'b1, 32'h20, 3'd2, 32'h1122_3344, d, r, w, wr);
        xfer(0, 1'b1, 32'h21, 3'd0, 32'h0000_A500, d, r, w, wr);
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (d !== 32'h1122_A544) begin fails++; $display("FAIL byte_write: got %h expected 1122a544", d); end
        xfer(0, 1'b1, 32'h22, 3'd1, 32'hCAFE_0000, d, r, w, wr);
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (d !== 32'hCAFE_A544) begin fails++; $display("FAIL half_write: got %h expected cafea544", d); end
    endtask

`ifdef AHB_SLAVE_MEM_ERR_EN
    task automatic test_error();
        logic [31:0] d; logic [1:0] r, wr; int w;
        xfer(0, 1'b1, 32'h0, 3'd2, 32'h600D_CAFE, d, r, w, wr);
        xfer(0, 1'b1, 32'h0000_1000, 3'd2, 32'hFFFF_FFFF, d, r, w, wr);
        tests++; if (w !== 1) begin fails++; $display("FAIL err_low_cycles: got %0d expected 1", w); end
        tests++; if (wr !== 2'b01) begin fails++; $display("FAIL err_resp_low: got %b expected 01", wr); end
        tests++; if (r !== 2'b01) begin fails++; $display("FAIL err_resp_high: got %b expected 01", r); end
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (d !== 32'h600D_CAFE) begin fails++; $display("FAIL err_mem_kept: got %h expected 600dcafe", d); end
        tests++; if (r !== 2'b00) begin fails++; $display("FAIL err_next_okay: got %b expected 00", r); end
        xfer(0, 1'b1, 32'h2, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (r !== 2'b01) begin fails++; $display("FAIL err_misaligned_word: got %b expected 01", r); end
        xfer(3, 1'b0, 32'h1, 3'd1, 32'h0, d, r, w, wr);
        tests++; if ({w[1:0], r} !== 4'b0101) begin fails++; $display("FAIL err_half_nowait: got %b expected 0101", {w[1:0], r}); end
    endtask
`else
    task automatic test_wrap();
        logic [31:0] d; logic [1:0] r, wr; int w;
        xfer(0, 1'b1, 32'h100, 3'd2, 32'h5A5A_5A5A, d, r, w, wr);
        tests++; if ({wr, r} !== 4'b0000) begin fails++; $display("FAIL wrap_resp: got %b expected 0000", {wr, r}); end
        xfer(0, 1'b0, 32'h0, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (d !== 32'h5A5A_5A5A) begin fails++; $display("FAIL wrap_rdata: got %h expected 5a5a5a5a", d); end
        xfer(0, 1'b1, 32'h0B, 3'd2, 32'hAABB_CCDD, d, r, w, wr);
        xfer(0, 1'b0, 32'h08, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (d !== 32'hAABB_CCDD) begin fails++; $display("FAIL mask_word: got %h expected aabbccdd", d); end
        xfer(0, 1'b1, 32'h08, 3'd3, 32'h0102_0304, d, r, w, wr);
        xfer(0, 1'b0, 32'h08, 3'd2, 32'h0, d, r, w, wr);
        tests++; if ({d, r} !== {32'h0102_0304, 2'b00}) begin fails++; $display("FAIL size3_word: got %h/%b expected 01020304/00", d, r); end
    endtask
`endif

    task automatic test_reset_in_wait();
        logic [31:0] d; logic [1:0] r, wr; int w;
        @(negedge HCLK);
        hsel3 = 1'b1; haddr = 32'h04; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(negedge HCLK);
        hsel3 = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
        tests++; if (rdy3 !== 1'b0) begin fails++; $display("FAIL rstw_in_wait: got %b expected 0", rdy3); end
        #1 HRESETn = 1'b0;
        #1;
        tests++; if ({rdy3, resp3} !== 3'b100) begin fails++; $display("FAIL rstw_outputs: got %b expected 100", {rdy3, resp3}); end
        tests++; if (rd3 !== 32'h0) begin fails++; $display("FAIL rstw_rdata: got %h expected 0", rd3); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        xfer(3, 1'b0, 32'h04, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rstw_discard: got %h expected 0", d); end
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, d, r, w, wr);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rstw_mem_clear: got %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_byte_lanes();
`ifdef AHB_SLAVE_MEM_ERR_EN
        test_error();
`else
        test_wrap();
`endif
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB slave responder with a word-addressed memory, programmable wait states and optional two-cycle ERROR response. It sits directly downstream of the AHB stimulus on the shared `ahb_if`. It consumes HTRANS/HADDR/HWRITE/HSIZE/HWDATA and drives HREADYOUT/HRESP/HRDATA, so the SVA/coverage bench sees protocol-correct slave behaviour.

## Interface
- `DEPTH`, 64: memory words; power of two, ≥4. `AW = $clog2(DEPTH)`.
- `WAIT_CYCLES`, 0: HREADYOUT-low cycles inserted per OKAY data phase (0..15).
- HCLK  in  1  clock; all state on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HBURST  in  3  accepted but ignored; every beat carries its own HADDR.
- HWDATA  in  32  write data, valid in data phase.
- HREADY  in  1  bus-level ready; address phase is sampled only when high.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  OKAY=00, ERROR=01.
- HRDATA  out  32  read data.

## Operation
- Accept: `HSEL && HREADY && HTRANS[1]` at a rising edge. The block latches addr_q, write_q and size_q, and the data phase starts. IDLE/BUSY or !HSEL get a zero-wait OKAY.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE → WAIT on accept if WAIT_CYCLES>0, else → DATA.
  - WAIT: HREADYOUT=0, HRESP=00. Down-counter loads WAIT_CYCLES on accept and decrements each cycle; → DATA when it reaches 1. Counter width is `$clog2(WAIT_CYCLES+1)`, and it never underflows.
  - DATA: HREADYOUT=1, HRESP=00. A write commits HWDATA to the array at the end of this cycle. For a read, HRDATA = mem[addr_q[AW+1:2]], combinational from the array. A new accept in this cycle → WAIT/DATA/ERR1 (pipelined back-to-back); otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=01 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. An accept in this cycle is handled like an accept from DATA; otherwise → IDLE.
- Byte lanes: little-endian. Byte write updates lane HADDR[1:0]; half write updates lanes {HADDR[1],0}/+1; word write updates all four lanes. Other bytes keep their values.
- HRDATA = 32'h0 whenever the block is not in DATA with write_q=0.
- Read-after-write to the same word in consecutive transfers returns the new data, because the commit completes before the read's data phase.
- BUSY or IDLE during a data phase does not disturb the pending transfer.

## Timing
- Reset (async assert, sync-safe deassert use):
  - HREADYOUT=1, HRESP=00, HRDATA=0.
  - State=IDLE, counter=0.
  - All memory words cleared to 0.
  - A write in flight is discarded.
- OKAY latency: read data and write completion land WAIT_CYCLES+1 cycles after the address-phase edge.
- ERROR is always exactly two cycles: low-ready then high-ready, with HRESP=01 held on both. An errored write never modifies memory.
- Address/control are sampled only at an accept edge. Changes while HREADY=0 are ignored.

## Configuration
- `AHB_SLAVE_MEM_ERR_EN` defined: ERROR is raised (ERR1/ERR2, no wait states applied) when any of these holds:
  - HADDR[31:AW+2] ≠ 0 (out of range);
  - HSIZE > 2;
  - half access with HADDR[0]=1;
  - word access with HADDR[1:0] ≠ 0.
- Undefined: ERR states are not built and HRESP is tied to 00.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH words.
  - Misaligned low address bits are masked to the access size.
  - HSIZE>2 is treated as a word access.

## Structure
- `ahb_pkg`: htrans enum, HRESP_OKAY/HRESP_ERROR constants, hsize enum, and the slave state enum.
- Sub-module `ahb_mem_array`: DEPTH×32 storage with an async-reset clear, a 4-bit byte-enable write port and an async read port.
- FSM, wait counter and decode live in `ahb_slave_mem`.

## Test plan
- WAIT_CYCLES=0: NONSEQ write 32'hDEAD_BEEF @0x10, then read @0x10 back-to-back → HREADYOUT never low; HRDATA=32'hDEAD_BEEF in the read data phase.
- WAIT_CYCLES=3: read @0x04 → HREADYOUT low for exactly 3 cycles, then high with HRDATA=0 (post-reset).
- Byte write 8'hA5 @0x21 after word write 32'h1122_3344 @0x20 → read @0x20 returns 32'h1122_A544.
- ERR_EN: write @0x0000_1000 with DEPTH=64 → two cycles HRESP=01 (HREADYOUT 0 then 1); a following read @0x0 returns the unchanged old value.
- Without ERR_EN: write 32'h5A5A_5A5A @0x100 → lands at word 0; read @0x0 returns 32'h5A5A_5A5A; HRESP stays 00.
- Assert HRESETn low during WAIT of a write → HREADYOUT=1, HRESP=00, HRDATA=0 immediately; memory reads back 0.
